// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: request/result bundle for the bit-serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   diff;
  modport master (output start, in1, in2, input busy, done, diff);
  modport slave  (input start, in1, in2, output busy, done, diff);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first one-bit-per-clock unsigned subtractor with borrow out
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   diff_q, diff_d;
  logic             bor_q, bor_d;
  logic             accept, shift, last, d, bor_n;
  assign accept = state_q == IDLE && bus.start;
  assign shift  = state_q == SHIFT;
  assign last   = cnt_q == CW'(WIDTH - 1);
  assign d      = a_q[0] ^ b_q[0] ^ bor_q;
  assign bor_n  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bor_q);
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE  ? (bus.start ? SHIFT : IDLE) :
              state_q == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  end
  // operands shift right so bit 0 is always the bit being processed
  always_comb begin
    a_d    = accept ? bus.in1 : shift ? a_q >> 1 : a_q;
    b_d    = accept ? bus.in2 : shift ? b_q >> 1 : b_q;
    cnt_d  = accept ? '0 : shift ? cnt_q + CW'(1) : cnt_q;
    bor_d  = accept ? 1'b0 : shift ? bor_n : bor_q;
    res_d  = accept ? '0 : shift ? {d, res_q[WIDTH-1:1]} : res_q;
    diff_d = (shift && last) ? {bor_n, d, res_q[WIDTH-1:1]} : diff_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      bor_q  <= 1'b0;
      res_q  <= '0;
      diff_q <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      bor_q  <= bor_d;
      res_q  <= res_d;
      diff_q <= diff_d;
    end
  end
  always_comb begin
    bus.busy = state_q != IDLE;
    bus.done = state_q == DONE;
    bus.diff = diff_q;
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized scoreboard bench against an arithmetic reference model
module tb_serial_subtractor;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  serial_subtractor_if #(.WIDTH(W)) bus ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [W:0] exp_q[$];
  int done_cyc[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask
  function automatic logic [W:0] model(input int a, input int b);
    logic [W:0] r;
    r[W]     = a < b;
    r[W-1:0] = W'((a - b + (1 << W)) % (1 << W));
    return r;
  endfunction
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_done", 1, 0);
      else check("diff", 32'(bus.diff), 32'(exp_q.pop_front()));
    end
  end
  task automatic run_op(input int a, input int b, input bit noisy);
    logic [W:0] e;
    e = model(a, b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1 = W'(a);
    bus.in2 = W'(b);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check("busy_accept", 32'(bus.busy), 1);
    check("done_accept", 32'(bus.done), 0);
    for (int k = 1; k <= W; k++) begin
      bus.start = noisy ? 1'($urandom) : 1'b0;
      bus.in1 = W'($urandom);
      bus.in2 = W'($urandom);
      @(posedge clk);
      #1;
      check("busy_run", 32'(bus.busy), 1);
      check("done_timing", 32'(bus.done), (k == W) ? 1 : 0);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_idle", 32'(bus.busy), 0);
    check("done_idle", 32'(bus.done), 0);
    @(posedge clk);
    #1;
    check("diff_hold", 32'(bus.diff), 32'(e));
  endtask
  initial begin
    bus.start = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_diff", 32'(bus.diff), 0);
    rst = 1'b0;
    run_op(9, 3, 0);
    check("lit_9_3", 32'(bus.diff), 32'(5'b0_0110));
    run_op(3, 9, 0);
    check("lit_3_9", 32'(bus.diff), 32'(5'b1_1010));
    run_op(0, 1, 0);
    check("lit_0_1", 32'(bus.diff), 32'(5'b1_1111));
    run_op(0, 0, 0);
    check("lit_0_0", 32'(bus.diff), 0);
    run_op(15, 15, 0);
    check("lit_15_15", 32'(bus.diff), 0);
    run_op(12, 5, 1);
    check("lit_noisy_12_5", 32'(bus.diff), 32'(5'b0_0111));
    for (int i = 0; i < 40; i++) run_op(int'($urandom_range(15)), int'($urandom_range(15)), 1);
    // start held high: accepts every WIDTH+2 clocks
    done_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.in1 = W'($urandom);
      bus.in2 = W'($urandom);
      exp_q.push_back(model(int'(bus.in1), int'(bus.in2)));
      @(posedge clk);
      #1;
      bus.in1 = W'($urandom);
      bus.in2 = W'($urandom);
      repeat (5) @(posedge clk);
    end
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    check("b2b_count", 32'(done_cyc.size()), 4);
    for (int i = 1; i < done_cyc.size(); i++)
      check("b2b_gap", 32'(done_cyc[i] - done_cyc[i-1]), W + 2);
    // reset in the second SHIFT cycle aborts with no done
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1 = 4'd5;
    bus.in2 = 4'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_diff", 32'(bus.diff), 0);
    repeat (8) @(posedge clk);
    run_op(7, 2, 0);
    check("lit_7_2", 32'(bus.diff), 32'(5'b0_0101));
    // reset and start together: reset wins
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    bus.in1 = 4'd9;
    bus.in2 = 4'd1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.start = 1'b0;
    check("rst_start_busy", 32'(bus.busy), 0);
    check("rst_start_diff", 32'(bus.diff), 0);
    repeat (8) @(posedge clk);
    #1;
    check("rst_start_quiet", 32'(bus.busy), 0);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) run_op(a, b, 0);
    repeat (3) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
